// File: rtl/alu_adder_arbiter_if.sv
// Requester/response bus of the shared ALU adder arbiter, together with the
// adder-side operand and tri-state result port.
interface alu_adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_add_sub;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   gnt;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_result;
    logic [2:0]           rsp_flags;
    logic                 busy;
    logic                 add_sub;
    logic                 oe;
    logic [7:0]           primary_operand;
    logic [7:0]           secondary_operand;
    logic [7:0]           adder_result;
    logic [2:0]           adder_flags;

    // Requesters plus the adder itself sit on the master side.
    modport master (
        output req, req_add_sub, req_a, req_b, adder_result, adder_flags,
        input  gnt, rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
               add_sub, oe, primary_operand, secondary_operand
    );

    modport slave (
        input  req, req_add_sub, req_a, req_b, adder_result, adder_flags,
        output gnt, rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
               add_sub, oe, primary_operand, secondary_operand
    );
endinterface

// File: rtl/alu_adder_arbiter.sv
// Round-robin arbiter sharing one 8-bit adder between NUM_REQ requesters;
// one operation per three cycles, response tagged with the requester id.
//
//   state   | meaning
//   IDLE    | waiting for a request; grants and latches operands this cycle
//   ISSUE   | latched op/operands driven; adder registers them at the edge
//   CAPTURE | adder output enabled; result/flags sampled at the edge
module alu_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clock,
    input  logic               nreset,
    alu_adder_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ID_W-1:0]      rr_ptr;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_ofs;
    logic [ID_W:0]        pick_sum;
    logic [ID_W-1:0]      pick_id;

    logic                 grant_ok;
    logic                 oe;
    logic                 busy;

    logic [ID_W-1:0]      lat_id;
    logic                 lat_add_sub;
    logic [7:0]           lat_a;
    logic [7:0]           lat_b;

    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_result;
    logic [2:0]           rsp_flags;

    // Rotate the request vector so bit k is requester (rr_ptr + k) mod NUM_REQ.
    assign req_dbl = {bus.req, bus.req} >> rr_ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        pick_found = 1'b0;
        pick_ofs   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_found = 1'b1;
                pick_ofs   = ID_W'(k);
            end
        end
    end

    assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_ofs};
    assign pick_id  = (pick_sum >= (ID_W+1)'(NUM_REQ))
                    ? ID_W'(pick_sum - (ID_W+1)'(NUM_REQ))
                    : pick_sum[ID_W-1:0];

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_ok   = 1'b0;
        oe         = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_ok   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                busy       = 1'b1;
                oe         = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Keep the result bus released and no grant visible while in reset.
        if (!nreset) begin
            grant_ok = 1'b0;
            oe       = 1'b0;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            rr_ptr      <= '0;
            lat_id      <= '0;
            lat_add_sub <= 1'b0;
            lat_a       <= '0;
            lat_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (grant_ok) begin
                lat_id      <= pick_id;
                lat_add_sub <= bus.req_add_sub[pick_id];
                lat_a       <= bus.req_a[{pick_id, 3'b000} +: 8];
                lat_b       <= bus.req_b[{pick_id, 3'b000} +: 8];
            end
            if (state == CAPTURE) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= lat_id;
                rsp_result <= bus.adder_result;
                rsp_flags  <= bus.adder_flags;
                rr_ptr     <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
            end
        end
    end

    assign bus.gnt               = grant_ok ? (NUM_REQ'(1) << pick_id) : '0;
    assign bus.oe                = oe;
    assign bus.busy              = busy;
    assign bus.add_sub           = lat_add_sub;
    assign bus.primary_operand   = lat_a;
    assign bus.secondary_operand = lat_b;
    assign bus.rsp_valid         = rsp_valid;
    assign bus.rsp_id            = rsp_id;
    assign bus.rsp_result        = rsp_result;
    assign bus.rsp_flags         = rsp_flags;

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Bench for alu_adder_arbiter: directed scenarios with literal expectations,
// then random requester traffic checked every cycle against a cycle-level model.
module tb_alu_adder_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clock = 1'b0;
    logic nreset;
    always #5 clock = ~clock;

    alu_adder_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

    alu_adder_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus)
    );

    // {carry/borrow, negative, zero, result[7:0]} from plain 9-bit arithmetic.
    function automatic logic [10:0] adder_eval(input logic add, input logic [7:0] a,
                                               input logic [7:0] b);
        logic [8:0] s;
        s = add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
        return {s[8], s[7], (s[7:0] == 8'h00), s[7:0]};
    endfunction

    // Adder stand-in: registers operands each edge; drives junk when not enabled.
    logic       add_q;
    logic [7:0] a_q, b_q, junk_r;
    logic [2:0] junk_f;
    always @(posedge clock) begin
        add_q  <= bus.add_sub;
        a_q    <= bus.primary_operand;
        b_q    <= bus.secondary_operand;
        junk_r <= 8'($urandom);
        junk_f <= 3'($urandom);
    end
    assign {bus.adder_flags, bus.adder_result} =
        bus.oe ? adder_eval(add_q, a_q, b_q) : {junk_f, junk_r};

    typedef struct {
        int         due;
        int         id;
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    op_t           pend[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            model_on = 1'b0;
    int            rr = 0;
    int            free_at = 0;
    logic [IW-1:0] last_id = '0;
    logic [7:0]    last_res = '0;
    logic [2:0]    last_fl = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (model_on) begin
            logic [N-1:0] e_gnt;
            logic         e_valid, e_oe, e_busy;
            logic [10:0]  fr;
            int           pick;
            op_t          o;
            e_gnt   = '0;
            e_valid = 1'b0;
            e_oe    = 1'b0;
            e_busy  = 1'b0;
            pick    = -1;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                fr       = adder_eval(pend[0].op, pend[0].a, pend[0].b);
                e_valid  = 1'b1;
                last_id  = IW'(pend[0].id);
                last_fl  = fr[10:8];
                last_res = fr[7:0];
                void'(pend.pop_front());
            end
            if (pend.size() > 0 && nreset) begin
                e_busy = 1'b1;
                e_oe   = (pend[0].due == cyc + 1);
                check("add_sub", 32'(bus.add_sub), 32'(pend[0].op));
                check("primary_operand", 32'(bus.primary_operand), 32'(pend[0].a));
                check("secondary_operand", 32'(bus.secondary_operand), 32'(pend[0].b));
            end
            if (nreset && cyc >= free_at && pend.size() == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && bus.req[(rr + k) % N]) pick = (rr + k) % N;
                end
                if (pick >= 0) begin
                    e_gnt[pick] = 1'b1;
                    o.due = cyc + 3;
                    o.id  = pick;
                    o.op  = bus.req_add_sub[pick];
                    o.a   = bus.req_a[8*pick +: 8];
                    o.b   = bus.req_b[8*pick +: 8];
                    pend.push_back(o);
                    rr      = (pick + 1) % N;
                    free_at = cyc + 3;
                end
            end
            check("gnt", 32'(bus.gnt), 32'(e_gnt));
            check("oe", 32'(bus.oe), 32'(e_oe));
            check("busy", 32'(bus.busy), 32'(e_busy));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
            check("rsp_id", 32'(bus.rsp_id), 32'(last_id));
            check("rsp_result", 32'(bus.rsp_result), 32'(last_res));
            check("rsp_flags", 32'(bus.rsp_flags), 32'(last_fl));
            if (!nreset) begin
                pend.delete();
                rr       = 0;
                free_at  = cyc + 1;
                last_id  = '0;
                last_res = '0;
                last_fl  = '0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    task automatic set_op(input int i, input logic add, input logic [7:0] a, input logic [7:0] b);
        bus.req[i]         = 1'b1;
        bus.req_add_sub[i] = add;
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    task automatic new_req(input int i);
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        case ($urandom_range(0, 7))
            0: a = 8'hFF;
            1: b = 8'h00;
            2: b = a;
            default: ;
        endcase
        set_op(i, 1'($urandom), a, b);
    endtask

    logic [N-1:0] g;

    initial begin
        nreset = 1'b0;
        bus.req = '1;
        bus.req_add_sub = '0;
        bus.req_a = '0;
        bus.req_b = '0;

        // Reset held two cycles with all requests up.
        tick();
        model_on = 1'b1;
        neg();
        check("t1_gnt", 32'(bus.gnt), 32'h0);
        check("t1_oe", 32'(bus.oe), 32'h0);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        nreset = 1'b1;
        bus.req = '0;
        neg();
        tick();

        // Single subtract on requester 0: 5 - 7.
        set_op(0, 1'b0, 8'h05, 8'h07);
        neg();
        check("t2_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = '0;
        neg();
        tick();
        neg();
        check("t2_oe", 32'(bus.oe), 32'h1);
        tick();
        neg();
        check("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("t2_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("t2_rsp_result", 32'(bus.rsp_result), 32'hFE);
        check("t2_rsp_flags", 32'(bus.rsp_flags), 32'h6);
        tick();

        // Overflowing add on requester 2: FF + 01.
        set_op(2, 1'b1, 8'hFF, 8'h01);
        neg();
        check("t3_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.req = '0;
        neg();
        tick();
        neg();
        tick();
        neg();
        check("t3_rsp_id", 32'(bus.rsp_id), 32'h2);
        check("t3_rsp_result", 32'(bus.rsp_result), 32'h00);
        check("t3_rsp_flags", 32'(bus.rsp_flags), 32'h5);
        tick();

        // Fairness from a fresh pointer: all four held for 12 cycles.
        nreset = 1'b0;
        neg();
        tick();
        nreset = 1'b1;
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c <= 12; c++) begin
            neg();
            if (c % 3 == 0 && c < 12) check("t4_gnt", 32'(bus.gnt), 32'(1 << (c / 3)));
            if (c % 3 == 0 && c > 0) begin
                check("t4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
                check("t4_rsp_id", 32'(bus.rsp_id), 32'(c / 3 - 1));
            end
            g = bus.gnt;
            tick();
            if (c == 11) bus.req = '0;
            else for (int i = 0; i < N; i++) if (g[i]) new_req(i);
        end

        // Reset asserted during CAPTURE drops the response; pointer returns to 0.
        new_req(2);
        bus.req = 4'b0100;
        neg();
        check("t5_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.req = '0;
        neg();
        tick();
        nreset = 1'b0;
        neg();
        check("t5_oe", 32'(bus.oe), 32'h0);
        tick();
        nreset = 1'b1;
        for (int i = 0; i < N; i++) new_req(i);
        neg();
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("t5_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = '0;
        for (int c = 0; c < 3; c++) begin
            neg();
            tick();
        end

        // Random traffic: requesters hold until granted, sometimes re-request or drop.
        for (int c = 0; c < 2000; c++) begin
            neg();
            g = bus.gnt;
            tick();
            nreset = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && g[i]) begin
                    if ($urandom_range(0, 1) == 1) new_req(i);
                    else bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
        end
        bus.req = '0;
        nreset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            neg();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
